// File: rtl/bbox_stream_reducer_pkg.sv
// rtl/bbox_stream_reducer_pkg.sv - shared types and constants for the bbox stream reducer
package bbox_stream_reducer_pkg;

  localparam int COORD_W_DEF = 24;

  // Identity values for a min/max fold at the default coordinate width
  localparam logic [COORD_W_DEF-1:0] COORD_POS_MAX = {1'b0, {(COORD_W_DEF-1){1'b1}}};
  localparam logic [COORD_W_DEF-1:0] COORD_NEG_MAX = {1'b1, {(COORD_W_DEF-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } reduce_state_e;

  // Width-24 views; x sits in the MSBs, min corner above max corner
  typedef struct packed {
    logic signed [COORD_W_DEF-1:0] x;
    logic signed [COORD_W_DEF-1:0] y;
    logic signed [COORD_W_DEF-1:0] z;
  } point;

  typedef struct packed {
    point min;
    point max;
  } bbox;

endpackage

// File: rtl/bbox_stream_reducer_if.sv
// rtl/bbox_stream_reducer_if.sv - primitive input stream and group result stream
interface bbox_stream_reducer_if
  import bbox_stream_reducer_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [3*COORD_W-1:0]   in_min;
  logic [3*COORD_W-1:0]   in_max;
  logic                   in_last;
  logic                   point_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [6*COORD_W-1:0]   out_bounds;
  logic [6*COORD_W-1:0]   out_cbounds;
  logic [CNT_W-1:0]       out_count;
  logic                   out_empty;
  logic                   out_dropped;
  logic                   out_sat;

  modport master (
    output in_valid, in_min, in_max, in_last, point_mode, out_ready,
    input  in_ready, out_valid, out_bounds, out_cbounds, out_count,
           out_empty, out_dropped, out_sat
  );

  modport slave (
    input  in_valid, in_min, in_max, in_last, point_mode, out_ready,
    output in_ready, out_valid, out_bounds, out_cbounds, out_count,
           out_empty, out_dropped, out_sat
  );
endinterface

// File: rtl/bbox_stream_reducer_axis_fold.sv
// rtl/bbox_stream_reducer_axis_fold.sv - one-axis degenerate check, centroid and min/max fold
module bbox_axis_fold #(
  parameter int COORD_W = 24
) (
  input  logic               point_mode_i,
  input  logic [COORD_W-1:0] in_min_i,
  input  logic [COORD_W-1:0] in_max_i,
  input  logic [COORD_W-1:0] acc_min_i,
  input  logic [COORD_W-1:0] acc_max_i,
  input  logic [COORD_W-1:0] cacc_min_i,
  input  logic [COORD_W-1:0] cacc_max_i,
  output logic               degen_o,
  output logic [COORD_W-1:0] min_o,
  output logic [COORD_W-1:0] max_o,
  output logic [COORD_W-1:0] cmin_o,
  output logic [COORD_W-1:0] cmax_o
);

  logic signed [COORD_W-1:0] mn;
  logic signed [COORD_W-1:0] mx;
  logic signed [COORD_W:0]   sum;
  logic signed [COORD_W-1:0] c;

  // Widen by one bit before halving so the midpoint floors and never wraps
  always_comb begin
    mn      = in_min_i;
    mx      = point_mode_i ? in_min_i : in_max_i;
    degen_o = mn > mx;
    sum     = {mn[COORD_W-1], mn} + {mx[COORD_W-1], mx};
    c       = sum[COORD_W:1];
    min_o   = ($signed(acc_min_i)  < mn) ? acc_min_i  : mn;
    max_o   = ($signed(acc_max_i)  > mx) ? acc_max_i  : mx;
    cmin_o  = ($signed(cacc_min_i) < c)  ? cacc_min_i : c;
    cmax_o  = ($signed(cacc_max_i) > c)  ? cacc_max_i : c;
  end

endmodule

// File: rtl/bbox_stream_reducer.sv
// rtl/bbox_stream_reducer.sv - folds groups of primitive bboxes into union/centroid bounds and a count
module bbox_stream_reducer
  import bbox_stream_reducer_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  bbox_stream_reducer_if.slave s
);

  localparam logic [COORD_W-1:0] POS_MAX = {1'b0, {(COORD_W-1){1'b1}}};
  localparam logic [COORD_W-1:0] NEG_MAX = {1'b1, {(COORD_W-1){1'b0}}};

  reduce_state_e state_q, state_d;

  // Index 2 is x so that the packed arrays line up with the {x,y,z} buses
  logic [2:0][COORD_W-1:0] imin, imax;
  logic [2:0][COORD_W-1:0] amin_q, amax_q, cmin_q, cmax_q;
  logic [2:0][COORD_W-1:0] fmin, fmax, fcmin, fcmax;
  logic [2:0][COORD_W-1:0] amin_d, amax_d, cmin_d, cmax_d;
  logic [2:0]              degen;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    drop_q, drop_d, sat_q, sat_d;
  logic                    accept, good;

  logic [6*COORD_W-1:0]    bounds_q, cbounds_q;
  logic [CNT_W-1:0]        count_q;
  logic                    empty_q, dropped_q, satflag_q;

  assign imin = s.in_min;
  assign imax = s.in_max;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    bbox_axis_fold #(.COORD_W(COORD_W)) u_fold (
      .point_mode_i (s.point_mode),
      .in_min_i     (imin[a]),
      .in_max_i     (imax[a]),
      .acc_min_i    (amin_q[a]),
      .acc_max_i    (amax_q[a]),
      .cacc_min_i   (cmin_q[a]),
      .cacc_max_i   (cmax_q[a]),
      .degen_o      (degen[a]),
      .min_o        (fmin[a]),
      .max_o        (fmax[a]),
      .cmin_o       (fcmin[a]),
      .cmax_o       (fcmax[a])
    );
  end

  // Accumulator view after folding the current beat (unchanged if nothing valid arrives)
  always_comb begin
    accept = s.in_valid && (state_q == ACCUM);
    good   = accept && !(|degen);
    amin_d = good ? fmin  : amin_q;
    amax_d = good ? fmax  : amax_q;
    cmin_d = good ? fcmin : cmin_q;
    cmax_d = good ? fcmax : cmax_q;
    cnt_d  = (good && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    sat_d  = sat_q | (good & (&cnt_q));
    drop_d = drop_q | (accept & (|degen));
  end

  // Next state: close the group on an accepted last beat, reopen on result handoff
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && s.in_last) state_d = HOLD;
      HOLD:    if (s.out_ready)          state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Accumulator and result registers; the accumulator reopens at identity with the result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amin_q    <= {3{POS_MAX}};
      amax_q    <= {3{NEG_MAX}};
      cmin_q    <= {3{POS_MAX}};
      cmax_q    <= {3{NEG_MAX}};
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      sat_q     <= 1'b0;
      bounds_q  <= '0;
      cbounds_q <= '0;
      count_q   <= '0;
      empty_q   <= 1'b0;
      dropped_q <= 1'b0;
      satflag_q <= 1'b0;
    end else if (accept) begin
      if (s.in_last) begin
        bounds_q  <= {amin_d, amax_d};
        cbounds_q <= {cmin_d, cmax_d};
        count_q   <= cnt_d;
        empty_q   <= (cnt_d == '0);
        dropped_q <= drop_d;
        satflag_q <= sat_d;
        amin_q    <= {3{POS_MAX}};
        amax_q    <= {3{NEG_MAX}};
        cmin_q    <= {3{POS_MAX}};
        cmax_q    <= {3{NEG_MAX}};
        cnt_q     <= '0;
        drop_q    <= 1'b0;
        sat_q     <= 1'b0;
      end else begin
        amin_q <= amin_d;
        amax_q <= amax_d;
        cmin_q <= cmin_d;
        cmax_q <= cmax_d;
        cnt_q  <= cnt_d;
        drop_q <= drop_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign s.in_ready    = (state_q == ACCUM);
  assign s.out_valid   = (state_q == HOLD);
  assign s.out_bounds  = bounds_q;
  assign s.out_cbounds = cbounds_q;
  assign s.out_count   = count_q;
  assign s.out_empty   = empty_q;
  assign s.out_dropped = dropped_q;
  assign s.out_sat     = satflag_q;

endmodule

// File: tb/tb_bbox_stream_reducer.sv
// tb/tb_bbox_stream_reducer.sv - directed bench with a group-level reference model
module tb_bbox_stream_reducer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bbox_stream_reducer_if #(.COORD_W(24), .CNT_W(16)) ifa ();
  bbox_stream_reducer_if #(.COORD_W(24), .CNT_W(4))  ifb ();

  bbox_stream_reducer #(.COORD_W(24), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .s(ifa.slave));
  bbox_stream_reducer #(.COORD_W(24), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .s(ifb.slave));

  logic        drv_valid = 0, drv_last = 0, drv_pm = 0, drv_oready = 0;
  logic [71:0] drv_min = '0, drv_max = '0;

  assign ifa.in_valid = drv_valid;  assign ifb.in_valid = drv_valid;
  assign ifa.in_min = drv_min;      assign ifb.in_min = drv_min;
  assign ifa.in_max = drv_max;      assign ifb.in_max = drv_max;
  assign ifa.in_last = drv_last;    assign ifb.in_last = drv_last;
  assign ifa.point_mode = drv_pm;   assign ifb.point_mode = drv_pm;
  assign ifa.out_ready = drv_oready; assign ifb.out_ready = drv_oready;

  int ncmp = 0, nfail = 0;
  bit pend = 0;
  logic [71:0] qmin[$], qmax[$];
  bit qpm[$];
  logic [143:0] ea_b, ea_c, eb_b, eb_c;
  int ea_n, eb_n;
  bit ea_e, ea_d, ea_s, eb_e, eb_d, eb_s;

  task automatic check(input string nm, input logic [143:0] act, input logic [143:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] p3(input int x, input int y, input int z);
    return {x[23:0], y[23:0], z[23:0]};
  endfunction

  function automatic logic [143:0] p6(input int a, input int b, input int c,
                                      input int d, input int e, input int f);
    return {p3(a, b, c), p3(d, e, f)};
  endfunction

  function automatic int ax(input logic [71:0] v, input int a);
    logic [23:0] t;
    t = v[48-24*a +: 24];
    return int'($signed(t));
  endfunction

  function automatic int floor_half(input int v);
    return (v >= 0) ? v / 2 : -((-v + 1) / 2);
  endfunction

  // Reference fold over the queued group, written as plain integer arithmetic
  task automatic model(input int cmax, output logic [143:0] eb, output logic [143:0] ec,
                       output int n, output bit emp, output bit drp, output bit sat);
    int lo[3], hi[3], clo[3], chi[3], mn[3], mx[3];
    bit bad;
    n = 0; drp = 0; sat = 0;
    for (int a = 0; a < 3; a++) begin
      lo[a] = 8388607; clo[a] = 8388607; hi[a] = -8388608; chi[a] = -8388608;
    end
    for (int i = 0; i < qmin.size(); i++) begin
      bad = 0;
      for (int a = 0; a < 3; a++) begin
        mn[a] = ax(qmin[i], a);
        mx[a] = qpm[i] ? mn[a] : ax(qmax[i], a);
        if (mn[a] > mx[a]) bad = 1;
      end
      if (bad) drp = 1;
      else begin
        for (int a = 0; a < 3; a++) begin
          int c;
          c = floor_half(mn[a] + mx[a]);
          if (mn[a] < lo[a]) lo[a] = mn[a];
          if (mx[a] > hi[a]) hi[a] = mx[a];
          if (c < clo[a]) clo[a] = c;
          if (c > chi[a]) chi[a] = c;
        end
        if (n == cmax) sat = 1;
        else n++;
      end
    end
    emp = (n == 0);
    eb = p6(lo[0], lo[1], lo[2], hi[0], hi[1], hi[2]);
    ec = p6(clo[0], clo[1], clo[2], chi[0], chi[1], chi[2]);
  endtask

  task automatic beat(input logic [71:0] mn, input logic [71:0] mx, input bit pm, input bit last);
    int n = 0;
    drv_valid = 1; drv_min = mn; drv_max = mx; drv_pm = pm; drv_last = last;
    while (!ifa.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    qmin.push_back(mn); qmax.push_back(mx); qpm.push_back(pm);
    if (last) begin
      model(65535, ea_b, ea_c, ea_n, ea_e, ea_d, ea_s);
      model(15, eb_b, eb_c, eb_n, eb_e, eb_d, eb_s);
      qmin.delete(); qmax.delete(); qpm.delete();
      pend = 1;
    end
    #1;
    drv_valid = 0; drv_last = 0; drv_pm = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ifa.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check("out_valid_timeout", 0, 1);
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(posedge clk);
    #1 drv_oready = 1;
    @(posedge clk);
    pend = 0;
    #1 drv_oready = 0;
  endtask

  // Per-cycle comparison of both instances against the reference model
  always @(negedge clk) begin
    if (!rst) begin
      check("a_out_valid", ifa.out_valid, pend);
      check("a_in_ready", ifa.in_ready, !pend);
      check("b_out_valid", ifb.out_valid, pend);
      check("b_in_ready", ifb.in_ready, !pend);
      if (pend && ifa.out_valid) begin
        check("a_bounds", ifa.out_bounds, ea_b);
        check("a_cbounds", ifa.out_cbounds, ea_c);
        check("a_count", ifa.out_count, ea_n[15:0]);
        check("a_flags", {ifa.out_empty, ifa.out_dropped, ifa.out_sat}, {ea_e, ea_d, ea_s});
      end
      if (pend && ifb.out_valid) begin
        check("b_bounds", ifb.out_bounds, eb_b);
        check("b_cbounds", ifb.out_cbounds, eb_c);
        check("b_count", ifb.out_count, eb_n[3:0]);
        check("b_flags", {ifb.out_empty, ifb.out_dropped, ifb.out_sat}, {eb_e, eb_d, eb_s});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_in_ready", ifa.in_ready, 1);
    check("rst_bounds", ifa.out_bounds, 0);
    check("rst_count", ifa.out_count, 0);
    check("rst_flags", {ifa.out_empty, ifa.out_dropped, ifa.out_sat}, 0);

    // Two-box group, then five cycles of backpressure
    beat(p3(0, 0, 0), p3(4, 4, 4), 0, 0);
    beat(p3(-2, 1, 1), p3(2, 6, 3), 0, 1);
    check("g1_valid_next", ifa.out_valid, 1);
    check("g1_bounds_lit", ifa.out_bounds, p6(-2, 0, 0, 4, 6, 4));
    check("g1_cbounds_lit", ifa.out_cbounds, p6(0, 2, 2, 2, 3, 2));
    check("g1_count_lit", ifa.out_count, 2);
    release_out(5);

    // Degenerate beat dropped, valid point-sized box kept
    beat(p3(5, 0, 0), p3(3, 0, 0), 0, 0);
    beat(p3(1, 1, 1), p3(1, 1, 1), 0, 1);
    wait_valid();
    check("g2_count_lit", ifa.out_count, 1);
    check("g2_dropped_lit", ifa.out_dropped, 1);
    check("g2_bounds_lit", ifa.out_bounds, p6(1, 1, 1, 1, 1, 1));
    release_out(0);

    // Empty group
    beat(p3(5, 0, 0), p3(3, 0, 0), 0, 1);
    wait_valid();
    check("g3_empty_lit", ifa.out_empty, 1);
    check("g3_count_lit", ifa.out_count, 0);
    check("g3_bounds_lit", ifa.out_bounds, {{3{24'h7FFFFF}}, {3{24'h800000}}});
    release_out(1);

    // Point mode at coordinate extremes; max bus ignored
    beat(p3(-8388608, 0, 0), p3(0, 0, 0), 1, 0);
    beat(p3(8388607, 0, 0), p3(0, 0, 0), 1, 1);
    wait_valid();
    check("g4_cbounds_lit", ifa.out_cbounds, p6(-8388608, 0, 0, 8388607, 0, 0));
    release_out(0);

    // Negative odd sum floors
    beat(p3(-3, 0, 0), p3(0, 0, 0), 0, 1);
    wait_valid();
    check("g5_cbounds_lit", ifa.out_cbounds, p6(-2, 0, 0, -2, 0, 0));
    release_out(0);

    // 17 valid beats: narrow counter saturates
    for (int i = 0; i < 17; i++) beat(p3(i, 0, 0), p3(i, 1, 1), 0, (i == 16));
    wait_valid();
    check("g6_a_count_lit", ifa.out_count, 17);
    check("g6_b_count_lit", ifb.out_count, 15);
    check("g6_b_sat_lit", ifb.out_sat, 1);
    check("g6_a_sat_lit", ifa.out_sat, 0);
    release_out(0);

    // Reset mid-group discards the partial accumulation
    for (int i = 0; i < 3; i++) beat(p3(-9, -9, -9), p3(9, 9, 9), 0, 0);
    rst = 1;
    qmin.delete(); qmax.delete(); qpm.delete();
    pend = 0;
    @(posedge clk);
    #1 rst = 0;
    check("rst2_out_valid", ifa.out_valid, 0);
    check("rst2_count", ifa.out_count, 0);
    beat(p3(7, 7, 7), p3(8, 8, 8), 0, 1);
    wait_valid();
    check("g7_count_lit", ifa.out_count, 1);
    check("g7_bounds_lit", ifa.out_bounds, p6(7, 7, 7, 8, 8, 8));
    release_out(0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/bbox_stream_reducer.md
# bbox_stream_reducer

Streaming bounding-box reducer for BVH construction. It accepts one primitive bbox per beat, or a point in point mode, over a valid/ready stream. It folds each group, delimited by `in_last`, into a union bbox, a centroid bbox and a primitive count. It sits between the primitive fetch stage and the BVH split-evaluation stage, and generalises the fixed 24-bit `bbox` record to a parametrised coordinate width with per-group reduction.

## Interface
Parameters:
- `COORD_W`, 24: signed fixed-point coordinate width per axis.
- `CNT_W`, 16: primitive counter width.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `in_min`  in  3*COORD_W  primitive min corner, {x,y,z}, x in MSBs.
- `in_max`  in  3*COORD_W  primitive max corner, same packing; ignored in point mode.
- `in_last`  in  1  final beat of group.
- `point_mode`  in  1  sampled per beat; 1 means primitive is the point `in_min`, so max = min.
- `out_valid`  out  1  group result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_bounds`  out  6*COORD_W  {min, max} union bbox.
- `out_cbounds`  out  6*COORD_W  {min, max} centroid bbox.
- `out_count`  out  CNT_W  primitives folded, saturating.
- `out_empty`  out  1  group contained no valid primitive.
- `out_dropped`  out  1  at least one primitive dropped as degenerate.
- `out_sat`  out  1  count saturated.

## Operation
- FSM has two states. ACCUM is entered on reset. HOLD is entered after `in_last` is accepted.
- In ACCUM, `in_ready`=1. Each accepted beat is checked per axis. If `min > max` (signed compare) on any axis, the beat is dropped: not folded, not counted, sticky dropped flag set.
- On a valid beat, the block folds:
  - `acc_min = min(acc_min, in_min)` and `acc_max = max(acc_max, in_max)` per axis.
  - The centroid `c = (min+max)>>>1` is formed at COORD_W+1 bits and arithmetic-shifted. This floors toward −inf and cannot overflow.
  - `c` is folded into `cacc_min` and `cacc_max`.
  - The count increments, saturating at 2^CNT_W−1 with `sat` set.
- The identity accumulator is min = +max signed (0x7FFFFF at W=24) and max = most negative (0x800000).
- On an accepted beat with `in_last`=1, the folded result including that beat is registered into the output regs, `out_valid`←1, FSM→HOLD. The accumulator and sticky flags return to identity in the same edge.
- In HOLD, `in_ready`=0. When `out_valid & out_ready`, `out_valid`←0 and FSM→ACCUM.
- For an empty group (every beat dropped), `out_empty`=1, the bounds outputs carry the identity values and `out_count`=0.
- Outputs hold stable while `out_valid & !out_ready`.

## Timing
- Reset values:
  - `out_valid`=0 and `in_ready`=1 once reset deasserts, ACCUM.
  - All output data regs and flags are 0.
  - The accumulator is at identity.
- Throughput is one beat per cycle within a group.
- Latency: `in_last` accepted at edge N gives `out_valid`=1 after edge N. If `out_ready`=1 at N+1, `in_ready`=1 after edge N+1. The minimum group-to-group gap is one bubble cycle.
- `in_ready` is a registered function of state only, with no combinational path from `out_ready`.
- Reset asserted mid-group discards the partial accumulation. Reset during HOLD discards the pending result.
- `point_mode` is sampled per beat, so mixed groups are legal.

## Structure
- `data_structs` gains:
  - `localparam COORD_W_DEF = 24`.
  - Identity constants `COORD_POS_MAX` and `COORD_NEG_MAX`, defined from the width.
  - An FSM state enum `reduce_state_e {ACCUM, HOLD}`.
  - The existing 24-bit `point` and `bbox` structs stay the width-24 views and must match the packed layout above.
- Sub-module `bbox_axis_fold`: combinational per-axis degenerate check, centroid and min/max fold. Parametrised by COORD_W and instantiated three times.

## Test plan
- Single group, 2 beats, W=24:
  - Input boxes (0,0,0)-(4,4,4) and (−2,1,1)-(2,6,3), last on beat 2.
  - Required: bounds (−2,0,0)-(4,6,4), cbounds (0,2,2)-(2,3,2), count 2, `out_valid` one cycle after beat 2.
- Degenerate drop: beats with min.x=5 > max.x=3, then valid (1,1,1)-(1,1,1) last. Required: count 1, `out_dropped`=1, bounds (1,1,1)-(1,1,1).
- Empty group: a single degenerate beat with last. Required: `out_empty`=1, count 0, bounds min=0x7FFFFF and max=0x800000 per axis.
- Backpressure: hold `out_ready`=0 for 5 cycles. Required: `in_ready`=0 throughout and outputs stable. Raising `out_ready` drops `out_valid` and raises `in_ready` the next cycle.
- Extremes and point mode:
  - Point (−8388608,·,·) and point (8388607,·,·), `point_mode`=1.
  - Required: centroid x values −8388608 and 8388607 (no overflow), and `(−3+0)>>>1 = −2` on a dedicated beat.
- Saturation and reset: CNT_W=4 with 17 valid beats gives count 15 and `out_sat`=1. Asserting `rst` mid-group, then a new one-beat group, gives count 1.
